// File: rtl/fifo_unpack_pkg.sv
// fifo_unpack_pkg
// Shared definitions for word-to-lane unpackers: the word/lane ratio, the
// lane index width derived from it, and the occupancy type of the small word
// buffer that sits in front of the lane selector.
package fifo_unpack_pkg;

    localparam int unsigned DEF_IN_WIDTH  = 64;
    localparam int unsigned DEF_OUT_WIDTH = 8;

    // Occupancy of the 2-entry word buffer (0..2).
    typedef logic [1:0] wcount_t;

    // Number of output lanes carried by one input word.
    function automatic int unsigned unpack_ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    // Bits needed to index a lane inside one word; ratio is a power of two >= 2.
    function automatic int unsigned unpack_lane_w(input int unsigned in_w, input int unsigned out_w);
        return $clog2(in_w / out_w);
    endfunction

endpackage

// File: rtl/fifo_unpack_if.sv
// fifo_unpack_if
// Bundles the fifo read port and the lane output stream of the unpacker.
//   fifo_dout/fifo_valid/fifo_empty : fifo -> unpacker (read data, read ack, empty)
//   fifo_rd_en                      : unpacker -> fifo (read enable)
//   out_data/out_valid              : unpacker -> sink
//   out_ready                       : sink -> unpacker
// Handshakes: fifo_valid is high exactly one cycle after a fifo_rd_en that the
// fifo accepted, and fifo_dout is meaningful only then. On the output stream a
// lane transfers on every rising edge where out_valid & out_ready; once
// out_valid is high, out_valid and out_data hold until that transfer happens.
interface fifo_unpack_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  fifo_dout;
    logic             fifo_valid;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // master: the unpacker.
    modport master (
        input  fifo_dout, fifo_valid, fifo_empty, out_ready,
        output fifo_rd_en, out_data, out_valid
    );

    // slave: the fifo plus the downstream sink.
    modport slave (
        output fifo_dout, fifo_valid, fifo_empty, out_ready,
        input  fifo_rd_en, out_data, out_valid
    );
endinterface

// File: rtl/fifo_unpack_wordbuf.sv
// fifo_unpack_wordbuf
// Two-entry word buffer (head/tail) with occupancy count.
//   clk, rst (sync, active low), flush : clock, reset, discard
//   push, din                           : write a word into the first free entry
//   pop                                 : drop the head, tail moves up
//   head_o                              : current head word
//   count_o                             : occupancy 0..2
// A push with the buffer full and no pop is dropped; the caller's credit
// scheme keeps that from happening.
module fifo_unpack_wordbuf
    import fifo_unpack_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head_o,
    output wcount_t      count_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    wcount_t      count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = din;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                // With a single entry a simultaneous pop frees the head, so
                // the new word lands there directly.
                if (push && pop) begin
                    head_d = din;
                end else if (push) begin
                    tail_d  = din;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = din;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
        if (flush) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifo_unpack.sv
// fifo_unpack
// Drains a common-clock fifo (1-cycle read latency) of wide words and emits
// them as narrower lanes, most significant lane first, on a valid/ready stream.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   flush      : synchronous discard of buffered and in-flight data
//   bus        : fifo read port + lane output stream (master side)
//   words_held : words currently buffered, 0..2
// The 2-entry buffer covers the fifo latency so a ready sink sees one lane
// per cycle once the first word has arrived.
module fifo_unpack
    import fifo_unpack_pkg::*;
#(
    parameter int in_width  = DEF_IN_WIDTH,
    parameter int out_width = DEF_OUT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    fifo_unpack_if.master bus,
    output logic [1:0]    words_held
);

    localparam int RATIO  = int'(unpack_ratio(in_width, out_width));
    localparam int LANE_W = int'(unpack_lane_w(in_width, out_width));
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]   lane_q;
    logic                inflight_q;
    logic [in_width-1:0] head;
    logic [in_width-1:0] head_shift;
    wcount_t             count;
    logic [2:0]          credit_used;
    logic                xfer;
    logic                push;
    logic                pop;

    // Credit counts only registered state: a pop in this cycle does not free
    // a slot until the next one, which keeps the enable free of out_ready.
    assign credit_used    = {1'b0, count} + {2'b00, inflight_q};
    assign bus.fifo_rd_en = rst & ~flush & ~bus.fifo_empty & (credit_used < 3'd2);

    // A word is accepted only if we asked for it; inflight_q is cleared by
    // reset/flush, so a late read ack after either is ignored.
    assign push = bus.fifo_valid & inflight_q;
    assign xfer = bus.out_valid & bus.out_ready;
    assign pop  = xfer & (lane_q == LAST_LANE);

    fifo_unpack_wordbuf #(
        .W (in_width)
    ) u_wordbuf (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .din     (bus.fifo_dout),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q     <= '0;
            inflight_q <= 1'b0;
        end else if (flush) begin
            lane_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= bus.fifo_rd_en;
            // Lane count is a power of two, so the increment wraps to lane 0
            // exactly when the head word pops.
            if (xfer) begin
                lane_q <= lane_q + 1'b1;
            end
        end
    end

    // Shift the selected lane up to the top so the slice is constant.
    assign head_shift    = head << (lane_q * out_width);
    assign bus.out_data  = head_shift[in_width-1 -: out_width];
    assign bus.out_valid = (count != 2'd0);
    assign words_held    = count;

endmodule

// File: tb/tb_fifo_unpack.sv
module tb_fifo_unpack;

    logic clk;
    logic rst;
    logic flush;
    logic [1:0] words_held;

    fifo_unpack_if #(.IN_W(64), .OUT_W(8)) bus ();

    fifo_unpack #(
        .in_width  (64),
        .out_width (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .words_held (words_held)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard / model state ----------------
    logic [7:0]  exp_q[$];
    logic [63:0] fifo_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          n_xfer;
    int          n_rd;
    int          first_xfer;
    int          last_xfer;
    int          hold_err;
    int          flow_err;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        last_rd;
    bit          ready_toggle;

    localparam logic [63:0] W_A = 64'h0011223344556677;
    localparam logic [63:0] W_B = 64'h8899AABBCCDDEEFF;
    localparam logic [63:0] W_C = 64'hF0E1D2C3B4A59687;
    localparam logic [63:0] W_D = 64'h13579BDF2468ACE0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_bytes(input logic [63:0] w);
        logic [63:0] t;
        for (int i = 0; i < 8; i++) begin
            t = w << (8 * i);
            exp_q.push_back(t[63:56]);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        fifo_q.push_back(w);
        add_bytes(w);
        bus.fifo_empty = 1'b0;
    endtask

    // After a discard, only words still in the fifo will ever be seen.
    task automatic rebuild_exp();
        exp_q.delete();
        foreach (fifo_q[i]) add_bytes(fifo_q[i]);
    endtask

    task automatic clear_stats();
        cyc        = 0;
        n_xfer     = 0;
        n_rd       = 0;
        first_xfer = -1;
        last_xfer  = -1;
        hold_err   = 0;
        flow_err   = 0;
        prev_stall = 1'b0;
    endtask

    // One clock: sample at negedge, then play the fifo model after posedge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        last_rd = bus.fifo_rd_en;
        if (last_rd) n_rd++;
        if (last_rd && bus.fifo_empty) flow_err++;
        if (words_held == 2'd3) flow_err++;
        if (prev_stall && !(bus.out_valid && bus.out_data === prev_data)) hold_err++;
        prev_stall = rst & ~flush & bus.out_valid & ~bus.out_ready;
        prev_data  = bus.out_data;
        if (!rst || flush) begin
            rebuild_exp();
        end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_lane", 64'(bus.out_data), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("lane_data", 64'(bus.out_data), 64'(e));
            end
            n_xfer++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        @(posedge clk);
        #1;
        bus.fifo_valid = last_rd;
        if (last_rd && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
        if (ready_toggle) bus.out_ready = ~bus.out_ready;
        cyc++;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        exp_q.delete();
        bus.fifo_empty = 1'b1;
        bus.out_ready  = 1'b0;
        ready_toggle   = 1'b0;
        flush          = 1'b0;
        rst            = 1'b0;
        tick();
        check("rst_rd_en", 64'(last_rd), 64'd0);
        rst = 1'b1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_words_held", 64'(words_held), 64'd0);
        clear_stats();
    endtask

    // Discard mid-word (lane 3) one cycle after a read was issued.
    task automatic discard_case(input bit use_rst);
        do_reset();
        bus.out_ready = 1'b1;
        push_word(W_A);
        repeat (4) tick();
        push_word(W_B);
        tick();
        check("dc_rd_prev", 64'(last_rd), 64'd1);
        check("dc_bytes_before", 64'(n_xfer), 64'd3);
        if (use_rst) rst = 1'b0;
        else flush = 1'b1;
        tick();
        rst   = 1'b1;
        flush = 1'b0;
        check("dc_out_valid", 64'(bus.out_valid), 64'd0);
        check("dc_words_held", 64'(words_held), 64'd0);
        if (use_rst) check("dc_out_data", 64'(bus.out_data), 64'd0);
        tick();
        check("dc_late_word_dropped", 64'(bus.out_valid), 64'd0);
        push_word(W_C);
        repeat (12) tick();
        check("dc_bytes_total", 64'(n_xfer), 64'd11);
        check("dc_sb_drained", 64'(exp_q.size()), 64'd0);
        check("dc_flow", 64'(flow_err), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst            = 1'b0;
        flush          = 1'b0;
        bus.fifo_dout  = '0;
        bus.fifo_valid = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.out_ready  = 1'b0;
        ready_toggle   = 1'b0;
        last_rd        = 1'b0;
        prev_data      = '0;
        clear_stats();
        @(posedge clk);
        #1;

        // Streaming with an always-ready sink.
        do_reset();
        bus.out_ready = 1'b1;
        push_word(W_A);
        push_word(W_B);
        repeat (20) tick();
        check("s1_first_cycle", 64'(first_xfer), 64'd2);
        check("s1_last_cycle", 64'(last_xfer), 64'd17);
        check("s1_bytes", 64'(n_xfer), 64'd16);
        check("s1_reads", 64'(n_rd), 64'd2);
        check("s1_sb_drained", 64'(exp_q.size()), 64'd0);

        // Sink ready alternates every cycle.
        do_reset();
        bus.out_ready = 1'b1;
        ready_toggle  = 1'b1;
        push_word(W_A);
        push_word(W_B);
        repeat (40) tick();
        ready_toggle = 1'b0;
        check("s2_bytes", 64'(n_xfer), 64'd16);
        check("s2_hold", 64'(hold_err), 64'd0);
        check("s2_flow", 64'(flow_err), 64'd0);
        check("s2_reads", 64'(n_rd), 64'd2);
        check("s2_sb_drained", 64'(exp_q.size()), 64'd0);

        // Fifo runs dry after one word, refilled later.
        do_reset();
        bus.out_ready = 1'b1;
        push_word(W_A);
        repeat (14) tick();
        check("s3_bytes_first_word", 64'(n_xfer), 64'd8);
        check("s3_gap_valid", 64'(bus.out_valid), 64'd0);
        first_xfer = -1;
        push_word(W_B);
        repeat (12) tick();
        check("s3_refill_latency", 64'(first_xfer), 64'd16);
        check("s3_bytes", 64'(n_xfer), 64'd16);
        check("s3_sb_drained", 64'(exp_q.size()), 64'd0);

        // Sink stalled with plenty of data: credit caps the reads.
        do_reset();
        bus.out_ready = 1'b0;
        push_word(W_A);
        push_word(W_B);
        push_word(W_C);
        push_word(W_D);
        repeat (8) tick();
        check("s4_reads_capped", 64'(n_rd), 64'd2);
        check("s4_words_held", 64'(words_held), 64'd2);
        check("s4_no_inflight", 64'(bus.fifo_valid), 64'd0);
        check("s4_stall_valid", 64'(bus.out_valid), 64'd1);
        check("s4_stall_data", 64'(bus.out_data), 64'h00);
        bus.out_ready = 1'b1;
        repeat (45) tick();
        check("s4_bytes", 64'(n_xfer), 64'd32);
        check("s4_reads", 64'(n_rd), 64'd4);
        check("s4_hold", 64'(hold_err), 64'd0);
        check("s4_flow", 64'(flow_err), 64'd0);
        check("s4_sb_drained", 64'(exp_q.size()), 64'd0);

        // Flush, then reset, mid-word right after a read.
        discard_case(1'b0);
        discard_case(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
